// File: rtl/clock_ui_pkg.sv
// Shared definitions for the alarm-clock user-interface blocks.
// Button indices, repeat-FSM states and small arbitration helpers.
package clock_ui_pkg;

    localparam int NUM_BTNS = 5;

    localparam int BTN_C = 4;
    localparam int BTN_D = 3;
    localparam int BTN_U = 2;
    localparam int BTN_R = 1;
    localparam int BTN_L = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // Highest-priority requester: C > D > U > R > L.
    function automatic logic [2:0] btn_winner(
        input logic [NUM_BTNS-1:0] req
    );
        logic [2:0] idx;
        idx = 3'd0;
        priority case (1'b1)
            req[BTN_C]: idx = 3'(BTN_C);
            req[BTN_D]: idx = 3'(BTN_D);
            req[BTN_U]: idx = 3'(BTN_U);
            req[BTN_R]: idx = 3'(BTN_R);
            req[BTN_L]: idx = 3'(BTN_L);
            default:    idx = 3'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [NUM_BTNS-1:0] btn_onehot(
        input logic [2:0] idx
    );
        return NUM_BTNS'(1) << idx;
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One push-button lane: 2-FF synchroniser, tick-based debounce
// counter, debounced level register and press (0->1) detector.
module btn_debounce_cell #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic       sync_a;
    logic       sync_b;
    logic [3:0] cnt;
    logic       flip;

    // Level toggles on the tick that completes the stable run.
    assign flip = tick && (sync_b != level)
               && (cnt == 4'(DEBOUNCE_TICKS - 1));
    assign rise = flip && !level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= 4'd0;
            level  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (tick) begin
                if (sync_b == level) begin
                    cnt <= 4'd0;
                end else if (flip) begin
                    level <= ~level;
                    cnt   <= 4'd0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/button_frontend.sv
// Button front-end: sample tick, per-button debounce, one-hot press
// arbitration and hold-to-repeat FSM for the alarm-clock controller.
module button_frontend
    import clock_ui_pkg::*;
#(
    parameter int TICK_DIV       = 250000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 200,
    parameter int REPEAT_RATE    = 40,
    parameter logic [NUM_BTNS-1:0] REPEAT_MASK = 5'b01100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_pulse,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic                repeating
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE)
                        ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);

    logic [TW-1:0]       tcnt;
    logic                tick;
    logic [NUM_BTNS-1:0] rise;
    logic                new_press;
    logic [2:0]          widx;
    rep_state_t          state;
    logic [RW-1:0]       rcnt;
    logic [2:0]          ridx;

    assign tick = (tcnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_cell
        btn_debounce_cell #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .raw  (btn_raw[g]),
            .level(btn_level[g]),
            .rise (rise[g])
        );
    end

    assign new_press = |rise;
    assign widx      = btn_winner(rise);

    // A new press always wins the output slot; losers are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rcnt      <= '0;
            ridx      <= 3'd0;
            btn_pulse <= '0;
            repeating <= 1'b0;
        end else begin
            btn_pulse <= '0;
            if (new_press) begin
                btn_pulse <= btn_onehot(widx);
                repeating <= 1'b0;
                if (REPEAT_MASK[widx]) begin
                    state <= DELAY;
                    ridx  <= widx;
                    rcnt  <= RW'(REPEAT_DELAY);
                end else begin
                    state <= IDLE;
                    rcnt  <= '0;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        repeating <= 1'b0;
                    end
                    DELAY, REPEAT: begin
                        if (!btn_level[ridx]) begin
                            state     <= IDLE;
                            rcnt      <= '0;
                            repeating <= 1'b0;
                        end else if (tick) begin
                            if (rcnt == RW'(1)) begin
                                btn_pulse <= btn_onehot(ridx);
                                rcnt      <= RW'(REPEAT_RATE);
                                state     <= REPEAT;
                                repeating <= 1'b1;
                            end else begin
                                rcnt <= rcnt - RW'(1);
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        repeating <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_frontend.sv
// Bench for button_frontend: directed table, corner sequences and
// random traffic against a tick-count reference model.
module tb_button_frontend;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] btn_raw = 5'b0;
    logic [4:0] btn_pulse;
    logic [4:0] btn_level;
    logic       repeating;

    always #5 clk = ~clk;

    button_frontend #(
        .TICK_DIV      (TD),
        .DEBOUNCE_TICKS(DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_RATE   (RR),
        .REPEAT_MASK   (5'b01100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_pulse(btn_pulse),
        .btn_level(btn_level),
        .repeating(repeating)
    );

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [4:0] rmask = 5'b01100;
    int         m_ncyc;
    logic [4:0] m_hist[$];
    logic [4:0] m_lvl;
    int         m_streak[5];
    bit         m_active;
    int         m_btn;
    int         m_ticks;
    logic [4:0] m_pulse;
    logic       m_rep;

    // observation counters
    int         ci;
    int         np;
    int         first_i;
    int         second_i;
    logic [4:0] first_v;
    int         nr;
    int         nd;

    typedef struct {
        logic [4:0] raw;
        int         hold;
        int         npulse;
        logic [4:0] first;
        int         first_at;
        int         second_at;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                         name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ncyc = 0;
        m_hist.delete();
        m_lvl = 5'b0;
        for (int i = 0; i < 5; i++) m_streak[i] = 0;
        m_active = 1'b0;
        m_btn = 0;
        m_ticks = 0;
        m_pulse = 5'b0;
        m_rep = 1'b0;
    endtask

    // One clock edge: expected outputs just after the edge.
    task automatic m_step(input logic [4:0] raw);
        logic [4:0] smp;
        logic [4:0] old_lvl;
        logic [4:0] rises;
        bit         tk;
        int         w;
        tk = (m_ncyc % TD) == (TD - 1);
        smp = (m_hist.size() == 2) ? m_hist[0] : 5'b0;
        old_lvl = m_lvl;
        rises = 5'b0;
        w = 0;
        if (tk) begin
            for (int i = 0; i < 5; i++) begin
                if (smp[i] != m_lvl[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] == DB) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_streak[i] = 0;
                        if (m_lvl[i]) rises[i] = 1'b1;
                    end
                end else begin
                    m_streak[i] = 0;
                end
            end
        end
        m_pulse = 5'b0;
        if (rises != 5'b0) begin
            for (int i = 0; i < 5; i++) if (rises[i]) w = i;
            m_pulse = 5'b1 << w;
            if (rmask[w]) begin
                m_active = 1'b1;
                m_btn = w;
                m_ticks = 0;
            end else begin
                m_active = 1'b0;
            end
        end else if (m_active) begin
            if (!old_lvl[m_btn]) begin
                m_active = 1'b0;
            end else if (tk) begin
                m_ticks++;
                if (m_ticks == RD ||
                    (m_ticks > RD && (m_ticks - RD) % RR == 0))
                    m_pulse = 5'b1 << m_btn;
            end
        end
        m_rep = m_active && (m_ticks >= RD);
        m_hist.push_back(raw);
        if (m_hist.size() > 2) void'(m_hist.pop_front());
        m_ncyc++;
    endtask

    task automatic clr();
        ci = 0;
        np = 0;
        first_i = -1;
        second_i = -1;
        first_v = 5'b0;
        nr = 0;
        nd = 0;
    endtask

    // Drive one cycle at the negedge, compare at the next negedge.
    task automatic cyc(input logic [4:0] raw);
        btn_raw = raw;
        @(posedge clk);
        if (rst) m_step(raw);
        else m_reset();
        @(negedge clk);
        chk("pulse", 32'(btn_pulse), 32'(m_pulse));
        chk("level", 32'(btn_level), 32'(m_lvl));
        chk("repeating", 32'(repeating), 32'(m_rep));
        chk("onehot", 32'($countones(btn_pulse) <= 1), 32'd1);
        if (btn_pulse != 5'b0) begin
            np++;
            if (np == 1) begin
                first_i = ci;
                first_v = btn_pulse;
            end
            if (np == 2) second_i = ci;
            if (btn_pulse == 5'b01000 && nr > 0) nd++;
            if (btn_pulse == 5'b00010) nr++;
        end
        ci++;
    endtask

    task automatic align();
        while ((m_ncyc % TD) != 0) cyc(5'b0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_pulse"}, 32'(btn_pulse), 32'd0);
        chk({name, "_level"}, 32'(btn_level), 32'd0);
        chk({name, "_rep"}, 32'(repeating), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] r;
        int h;

        tbl[0] = '{5'b00010, 40, 1, 5'b00010, 11, -1};
        tbl[1] = '{5'b00100, 96, 11, 5'b00100, 11, 31};
        tbl[2] = '{5'b10001, 40, 1, 5'b10000, 11, -1};
        tbl[3] = '{5'b01100, 40, 4, 5'b01000, 11, 31};
        tbl[4] = '{5'b00001, 40, 1, 5'b00001, 11, -1};
        tbl[5] = '{5'b01000, 16, 1, 5'b01000, 11, -1};
        tbl[6] = '{5'b11111, 40, 1, 5'b10000, 11, -1};

        m_reset();
        clr();
        repeat (3) @(negedge clk);
        btn_raw = 5'b11111;
        @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        btn_raw = 5'b0;
        rst = 1'b1;
        m_reset();

        for (int v = 0; v < 7; v++) begin
            align();
            clr();
            repeat (tbl[v].hold) cyc(tbl[v].raw);
            repeat (24) cyc(5'b0);
            chk($sformatf("v%0d_npulse", v), 32'(np), 32'(tbl[v].npulse));
            chk($sformatf("v%0d_first", v), 32'(first_v), 32'(tbl[v].first));
            chk($sformatf("v%0d_first_at", v), 32'(first_i),
                32'(tbl[v].first_at));
            chk($sformatf("v%0d_second_at", v), 32'(second_i),
                32'(tbl[v].second_at));
            chk($sformatf("v%0d_level_end", v), 32'(btn_level), 32'd0);
            chk($sformatf("v%0d_rep_end", v), 32'(repeating), 32'd0);
        end

        // bounce on C, then a stable hold
        align();
        clr();
        for (int j = 0; j < 30; j++)
            cyc(((j / 3) % 2 == 0) ? 5'b10000 : 5'b00000);
        chk("bounce_quiet", 32'(np), 32'd0);
        repeat (40) cyc(5'b10000);
        chk("bounce_npulse", 32'(np), 32'd1);
        chk("bounce_first", 32'(first_v), 32'h10);
        chk("bounce_first_at", 32'(first_i), 32'd43);
        repeat (24) cyc(5'b0);

        // repeat cancel: D repeating, then R pressed
        align();
        clr();
        for (int k = 0; k < 60 && !repeating; k++) cyc(5'b01000);
        chk("cancel_rep_up", 32'(repeating), 32'd1);
        chk("cancel_rep_at", 32'(ci), 32'd32);
        repeat (50) cyc(5'b01010);
        chk("cancel_r_pulses", 32'(nr), 32'd1);
        chk("cancel_d_after", 32'(nd), 32'd0);
        chk("cancel_rep_low", 32'(repeating), 32'd0);
        repeat (24) cyc(5'b0);

        // reset in the middle of a U repeat sequence
        align();
        clr();
        for (int k = 0; k < 60 && !repeating; k++) cyc(5'b00100);
        chk("rst_rep_up", 32'(repeating), 32'd1);
        rst = 1'b0;
        m_reset();
        #1;
        chk_zero("rst_async");
        repeat (5) cyc(5'b00100);
        rst = 1'b1;
        clr();
        repeat (60) cyc(5'b00100);
        chk("rst_npulse", 32'(np), 32'd5);
        chk("rst_first", 32'(first_v), 32'h04);
        chk("rst_first_at", 32'(first_i), 32'd11);
        chk("rst_second_at", 32'(second_i), 32'd31);
        repeat (24) cyc(5'b0);

        // random traffic against the model
        for (int s = 0; s < 250; s++) begin
            case ($urandom_range(0, 3))
                0: r = 5'($urandom);
                1: r = 5'b0;
                default: r = 5'b1 << $urandom_range(0, 4);
            endcase
            h = $urandom_range(1, 50);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b0;
                m_reset();
                #1;
                chk_zero("rnd_rst");
                repeat (3) cyc(r);
                rst = 1'b1;
            end
            repeat (h) cyc(r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_frontend.md
# button_frontend

Input front-end for the alarm-clock controller: it takes the five raw board push-buttons (C, D, U, R, L) and produces clean single-cycle press events for the mode FSM. Each button is synchronised and debounced on a divided sample tick. U and D get hold-to-repeat for fast time and alarm setting. Output events are strictly one-hot, so the FSM's exact-match button decoding never sees two bits set at once.

## Interface
- TICK_DIV, 250000: `clk` cycles per sample tick (2.5 ms at 100 MHz).
- DEBOUNCE_TICKS, 4: consecutive equal samples required to change a debounced level (1..15).
- REPEAT_DELAY, 200: ticks a repeat-capable button must be held before the first repeat event.
- REPEAT_RATE, 40: ticks between subsequent repeat events.
- REPEAT_MASK, 5'b01100: buttons with auto-repeat (bit4 C, bit3 D, bit2 U, bit1 R, bit0 L).
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset (0 = reset).
- btn_raw  input  5  raw pad levels, bit order C,D,U,R,L (bit4..bit0), active-high.
- btn_pulse  output  5  one-hot press or repeat event, high for exactly one `clk` cycle.
- btn_level  output  5  debounced button levels.
- repeating  output  1  high while a repeat sequence is active (REPEAT state).

## Operation
- **Tick.** A free-running counter counts 0..TICK_DIV-1. `tick` is high for one `clk` when the count equals TICK_DIV-1, then the count wraps to 0.
- **Sync.** Each `btn_raw` bit passes through a 2-FF synchroniser before any other use.
- **Debounce (per button).** On each tick:
  - If the synced sample equals `btn_level`, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_TICKS, `btn_level` toggles and the counter clears.
  - Between ticks, levels and counters hold.
- **Press detect.** A 0->1 edge of `btn_level[i]` is a new press of button i. A 1->0 edge is a release and generates no event.
- **Arbitration.**
  - Simultaneous new presses: priority C > D > U > R > L. Only the winner is emitted; the others are dropped, not queued.
  - A new press always beats a repeat event in the same cycle. That repeat event is dropped.
- **Repeat FSM** (states IDLE, DELAY, REPEAT):
  - IDLE: on an emitted new press of a REPEAT_MASK button, latch its index, load `rcnt` = REPEAT_DELAY, and go to DELAY.
  - DELAY: on each tick, decrement `rcnt`. When `rcnt` reaches 0, emit a pulse on the latched index, load `rcnt` = REPEAT_RATE, and go to REPEAT.
  - REPEAT: on each tick, decrement `rcnt`. When `rcnt` reaches 0, emit the latched pulse and reload REPEAT_RATE.
  - In DELAY or REPEAT, the FSM goes to IDLE when the latched button's `btn_level` falls.
  - In DELAY or REPEAT, any other emitted new press cancels the sequence. If that button is in REPEAT_MASK, the FSM restarts DELAY for it; otherwise it goes to IDLE.
  - A new press of a non-mask button never enters DELAY.
- **Reset (asserted).** The following are 0: all outputs, the tick counter, sync FFs, levels, debounce counters and `rcnt`; the FSM is in IDLE.
- **Reset asserted mid-operation** aborts everything immediately; no pulse is emitted during or on release of reset.
- **Button held through reset release.** Its level rises after debounce and it is treated as a new press, so one pulse is emitted.

## Timing
- `btn_pulse` and `repeating` are registered outputs.
- **New-press latency.** The debounced level rises on the tick that completes DEBOUNCE_TICKS stable samples. `btn_pulse` is high in the next `clk` cycle, for one cycle.
- **Raw-to-pulse latency.** Raw edge to pulse is at most 2 + TICK_DIV·(DEBOUNCE_TICKS+1) + 1 cycles.
- **First repeat.** Emitted the `clk` cycle after the REPEAT_DELAY-th tick following the press pulse.
- **Later repeats.** Spaced exactly REPEAT_RATE·TICK_DIV `clk` cycles apart.
- **`repeating` timing.** Rises in the same cycle as the first repeat pulse and falls the cycle after the FSM leaves REPEAT.
- **Width rules.** Tick counter is $clog2(TICK_DIV) bits. `rcnt` is $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1) bits.
- **One-hot guarantee.** `btn_pulse` has at most one bit set in any cycle.

## Structure
- **Shared package `clock_ui_pkg`:**
  - button index constants BTN_C=4, BTN_D=3, BTN_U=2, BTN_R=1, BTN_L=0;
  - NUM_BTNS=5;
  - repeat-state encoding constants IDLE/DELAY/REPEAT.
- **Sub-module `btn_debounce_cell`:** one instance per button, containing the sync FFs, debounce counter, level register and rise detector.
- **Top level:** tick counter, arbiter and repeat FSM.

## Test plan
All directed tests run with TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2.

- **Clean press.** Hold `btn_raw`=5'b00010 for 40 cycles, then release -> exactly one `btn_pulse`=5'b00010 within 2+16+1 cycles; `btn_level[1]` falls after release; no repeat.
- **Bounce rejection.** Toggle `btn_raw[4]` every 3 cycles for 30 cycles, then hold high -> no pulse during the bounce; a single 5'b10000 pulse after 3 stable ticks.
- **Auto-repeat.** Hold U (5'b00100) for 100 cycles -> initial pulse, first repeat 20 cycles later, then repeats every 8 cycles; `repeating`=1 from the first repeat; release -> `repeating` returns to 0 and no further pulses.
- **Simultaneous press.** `btn_raw` goes 0 -> 5'b10001 in one cycle -> only 5'b10000 is emitted and L is dropped; D+U together -> only 5'b01000 is emitted.
- **Repeat cancel.** Hold D until `repeating`=1, then press R -> one 5'b00010 pulse, FSM goes to IDLE, and no more D repeats while D is still held.
- **Reset mid-hold.** Drive `rst`=0 during a U repeat sequence -> all outputs 0 immediately; release `rst` with U still held -> one new U pulse after debounce, then repeats resume after REPEAT_DELAY ticks.
